// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, defaults and helpers for the UART receiver
//
// Purpose: receiver FSM state type, default frame geometry, bit-centre
//          position and the 3-sample majority vote.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned DEF_WORD_SIZE   = 8;
  localparam int unsigned DEF_PACKET_SIZE = DEF_WORD_SIZE + 2;
  localparam int unsigned DEF_PULSE_WIDTH = 868;

  // Counter value at the nominal centre of a bit period.
  function automatic int unsigned mid_of(input int unsigned pulse_width);
    return pulse_width / 2;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_sampler.sv
// rtl/uart_rx_sync_sampler.sv - rx synchroniser, falling-edge detect and bit-centre sampler
//
// Purpose: brings the asynchronous rx line into the clk domain, flags its
//          falling edge, runs the per-bit counter and majority-votes three
//          samples taken at MID-1, MID and MID+1.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx                asynchronous serial input, idle high
//   clear_i           hold the bit counter at 0 on the next edge
//   rx_s_o            synchronised rx
//   fall_o            rx_s has just gone 1 -> 0
//   sample_valid_o    counter is at MID+1; sample_bit_o is the voted bit
//   sample_bit_o      majority of the three centre samples
//   wrap_o            counter is at its last value of the bit period
module uart_rx_sync_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PULSE_WIDTH = DEF_PULSE_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic clear_i,
  output logic rx_s_o,
  output logic fall_o,
  output logic sample_valid_o,
  output logic sample_bit_o,
  output logic wrap_o
);

  localparam int unsigned CNT_W = $clog2(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_MID_M1 = CNT_W'(mid_of(PULSE_WIDTH) - 1);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(mid_of(PULSE_WIDTH));
  localparam logic [CNT_W-1:0] CNT_MID_P1 = CNT_W'(mid_of(PULSE_WIDTH) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PULSE_WIDTH - 1);

  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             samp0_q;
  logic             samp1_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      samp0_q   <= 1'b1;
      samp1_q   <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      cnt_q     <= cnt_d;
      if (cnt_q == CNT_MID_M1) begin
        samp0_q <= rx_s_q;
      end
      if (cnt_q == CNT_MID) begin
        samp1_q <= rx_s_q;
      end
    end
  end

  // The third vote is the live MID+1 sample, so the decision lands on the
  // same edge as the last sample instead of one cycle later.
  assign rx_s_o         = rx_s_q;
  assign fall_o         = rx_prev_q & ~rx_s_q;
  assign sample_valid_o = (cnt_q == CNT_MID_P1);
  assign sample_bit_o   = majority3(samp0_q, samp1_q, rx_s_q);
  assign wrap_o         = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_sampled.sv
// rtl/uart_rx_sampled.sv - 8N1 UART receiver with majority sampling and ready/valid output
//
// Purpose: frames the synchronised rx stream (start, WORD_SIZE data bits LSB
//          first, stop), delivers words on a ready/valid port and reports
//          framing errors and overruns as one-cycle pulses.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   rx             asynchronous serial line, idle high
//   rx_ready       consumer accepts the word when rx_valid && rx_ready
//   data_bits_rx   received word, stable while rx_valid is high
//   rx_valid       word available
//   frame_err      one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: word completed while the previous one is unaccepted
//   busy           receiver is not idle
module uart_rx_sampled
  import uart_pkg::*;
#(
  parameter int unsigned WORD_SIZE   = DEF_WORD_SIZE,
  parameter int unsigned PULSE_WIDTH = DEF_PULSE_WIDTH,
  parameter int unsigned PACKET_SIZE = DEF_PACKET_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [WORD_SIZE-1:0] data_bits_rx,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(WORD_SIZE);
  // Last data slot: frame length minus start, stop and the zero-based offset.
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACKET_SIZE - 3);

  rx_state_t            state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_SIZE-1:0] shreg_q, shreg_d;
  logic [WORD_SIZE-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic rx_s;
  logic fall;
  logic sample_valid;
  logic sample_bit;
  logic wrap;
  logic cnt_clear;
  logic deliver;
  logic stop_bad;

  uart_rx_sync_sampler #(
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .clear_i       (cnt_clear),
    .rx_s_o        (rx_s),
    .fall_o        (fall),
    .sample_valid_o(sample_valid),
    .sample_bit_o  (sample_bit),
    .wrap_o        (wrap)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        // A start bit that votes high was a glitch: drop it silently.
        if (sample_valid && sample_bit) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (sample_valid) begin
          shreg_d[idx_q] = sample_bit;
        end
        if (wrap) begin
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        // Leave STOP at the centre sample, not at the end of the bit, so a
        // start bit that follows immediately is still seen as a fresh edge.
        if (sample_valid) begin
          if (sample_bit) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The counter runs only while a frame is in progress; in IDLE it rests at 0
  // so the edge-detect cycle itself is count 0.
  assign cnt_clear = (state_d == IDLE) || (state_d == BREAK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= stop_bad;
      overrun_q   <= deliver && valid_q && !rx_ready;
      if (deliver && (!valid_q || rx_ready)) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_bits_rx = data_q;
  assign rx_valid     = valid_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampled.sv
// tb/tb_uart_rx_sampled.sv - scoreboard bench for uart_rx_sampled
module tb_uart_rx_sampled;

  localparam int PW  = 8;
  localparam int WS  = 8;
  localparam int MID = PW / 2;
  localparam int LAT = 2 + (WS + 1) * PW + MID + 1 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          rx_ready;
  logic [WS-1:0] data_bits_rx;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  uart_rx_sampled #(
    .WORD_SIZE  (WS),
    .PULSE_WIDTH(PW),
    .PACKET_SIZE(WS + 2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_ready    (rx_ready),
    .data_bits_rx(data_bits_rx),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int start_cyc = 0;
  int rise_cyc  = -1000;
  int run_len   = 0;
  int last_len  = 0;
  logic prev_valid = 1'b0;
  logic [WS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    logic [31:0] want;
    if (!rst) begin
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (rx_valid) run_len++;
      else if (prev_valid) begin
        last_len = run_len;
        run_len  = 0;
      end
      if (rx_valid && rx_ready) begin
        want = 32'h100;
        if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
        check("sb_word", 32'(data_bits_rx), want);
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err || overrun) check("fe_ov_exclusive", 32'(frame_err & overrun), 32'd0);
    end
    prev_valid = rx_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit-banger: one frame, optional 1-clock inversion at MID of data bit
  // glitch_bit, optional 1-clock reset at MID of data bit rst_bit.
  task automatic send_frame(input logic [WS-1:0] b, input logic stop_val,
                            input int glitch_bit, input int rst_bit);
    logic [WS+1:0] f;
    f = {stop_val, b, 1'b0};
    for (int k = 0; k < WS + 2; k++) begin
      for (int c = 0; c < PW; c++) begin
        @(posedge clk);
        #1;
        if (k == 0 && c == 0) start_cyc = cyc;
        rx = f[k];
        if (k == glitch_bit + 1 && c == MID) rx = ~f[k];
        if (k == rst_bit + 1 && c == MID) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          check("rst_valid", 32'(rx_valid), 32'd0);
          check("rst_data", 32'(data_bits_rx), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_fe", 32'(frame_err), 32'd0);
          check("rst_ov", 32'(overrun), 32'd0);
          rst = 1'b0;
          rx  = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    logic [WS-1:0] b2b[10];
    int fe0;
    int ov0;
    b2b = '{8'h55, 8'hA3, 8'h7E, 8'h00, 8'hFF, 8'hC3, 8'h3C, 8'h5A, 8'h81, 8'h1E};

    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    idle(3);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_data", 32'(data_bits_rx), 32'd0);
    check("reset_fe", 32'(frame_err), 32'd0);
    check("reset_ov", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(2 * PW);

    // Single word with latency and one-cycle valid.
    exp_q.push_back(8'h21);
    send_frame(8'h21, 1'b1, -10, -10);
    idle(2 * PW);
    check("latency", 32'(rise_cyc - start_cyc), 32'(LAT));
    check("valid_len", 32'(last_len), 32'd1);
    check("single_fe", 32'(fe_cnt), 32'd0);
    check("single_drain", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames, no idle gap.
    ov0 = ov_cnt;
    foreach (b2b[i]) exp_q.push_back(b2b[i]);
    foreach (b2b[i]) send_frame(b2b[i], 1'b1, -10, -10);
    idle(2 * PW);
    check("b2b_drain", 32'(exp_q.size()), 32'd0);
    check("b2b_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // One-clock low glitch on the idle line.
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(MID + 3);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_no_word", 32'(rise_cyc - start_cyc), 32'(LAT));

    // Inverted clock at the centre of bit 3 is outvoted.
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 3, -10);
    idle(2 * PW);
    check("vote_drain", 32'(exp_q.size()), 32'd0);

    // Stop bit low, line held low, then a good frame.
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, -10, -10);
    idle(30);
    rx = 1'b1;
    idle(2 * PW);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -10, -10);
    idle(2 * PW);
    check("frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("frame_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure: second word is dropped with one overrun pulse.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -10, -10);
    send_frame(8'h22, 1'b1, -10, -10);
    idle(2 * PW);
    check("bp_overrun", 32'(ov_cnt - ov0), 32'd1);
    check("bp_valid", 32'(rx_valid), 32'd1);
    check("bp_data_held", 32'(data_bits_rx), 32'h11);
    rx_ready = 1'b1;
    idle(1);
    check("bp_valid_drop", 32'(rx_valid), 32'd0);
    check("bp_drain", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 4 with a word pending, then a clean frame.
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, -10, -10);
    idle(PW);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    send_frame(8'h99, 1'b1, -10, 4);
    idle(3 * PW);
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, -10, -10);
    idle(2 * PW);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampled.md
Name: uart_rx_sampled

Overview:
Standalone UART receiver: the receiving end of the 8N1 serial stream produced by the team's UART transmitter path.
- Synchronises the asynchronous rx line and qualifies the start bit.
- Majority-votes three samples around each bit centre.
- Delivers words on a ready/valid interface with framing-error and overrun reporting.
- Sits between the board RX pin and the command/FIFO logic.

Parameters:
WORD_SIZE, 8, data bits per frame, LSB first
PULSE_WIDTH, 868, clocks per bit (CLOCK_FREQ/BAUD); minimum 4
PACKET_SIZE, 10, start + WORD_SIZE + stop; must equal WORD_SIZE+2

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx  input  1  asynchronous serial line, idle high
rx_ready  input  1  consumer accepts word when rx_valid && rx_ready
data_bits_rx  output  WORD_SIZE  received word, stable while rx_valid high
rx_valid  output  1  word available
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: word completed while rx_valid still high
busy  output  1  high in any state other than IDLE

Behaviour:
- Interface (fixed): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: data_bits_rx=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops reset to 1.
  - FSM resets to IDLE.
  - Reset mid-frame aborts the frame; no output pulse is produced.
- Input path: rx passes through 2 flops to give rx_s.
  - Falling-edge detect compares rx_s with its previous value.
  - All timing is measured from the edge-detect cycle.
- Bit counter: cnt counts 0..PULSE_WIDTH-1 and wraps.
  - MID = PULSE_WIDTH/2 (integer division).
  - Samples are taken at cnt = MID-1, MID, MID+1.
  - Bit value = majority of the 3 samples.
- States:
  - IDLE: on a falling edge of rx_s, clear cnt and go to START.
  - START: at cnt=MID+1, if the majority is 0 go to DATA; else (glitch) return to IDLE with no output. At cnt wrap, enter DATA with bit index 0.
  - DATA: shift the majority bit into bit index i (LSB first) at cnt=MID+1. At wrap with i=WORD_SIZE-1, go to STOP; else i++.
  - STOP: at cnt=MID+1, evaluate the majority.
    - If 1: deliver the word and go to IDLE on the same edge, so a back-to-back start is caught.
    - If 0: pulse frame_err, discard the word, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents re-triggering on a held-low line.
- Delivery:
  - If rx_valid=0 (or rx_valid=1 and rx_ready=1 in the same cycle), load data_bits_rx and set rx_valid on the next edge.
  - If rx_valid=1 and rx_ready=0: pulse overrun, drop the new word, keep the old word unchanged.
- Handshake: rx_valid falls on the edge after rx_valid && rx_ready. rx_valid never drops without acceptance, except on reset.
- Latency: rx_valid rises exactly 1 clk after the STOP cnt=MID+1 sample edge.
  - In absolute terms: 2 (sync) + (PACKET_SIZE-1)·PULSE_WIDTH + MID+1 + 1 clocks after rx falls.
- Simultaneous events: a frame_err can coincide with a pending rx_valid; both are reported independently. frame_err and overrun never pulse in the same cycle.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}
  - localparams for default WORD_SIZE and PACKET_SIZE
  - function mid_of(PULSE_WIDTH)
  - majority3 function
- Sub-module uart_rx_sync_sampler: 2-flop synchroniser, falling-edge detect, 3-sample capture.
  - Output sample_valid fires at cnt=MID+1 with the voted bit.
- Top module: FSM, shift register, output handshake.

Test Plan:
- Bench setup: PULSE_WIDTH=8, WORD_SIZE=8. Drive rx from a bench bit-banger or the team's transmitter with tx looped to rx.
- Single word: send 8'h21 with rx_ready=1 -> rx_valid for 1 cycle, data_bits_rx=8'h21, frame_err=0. Check rx_valid timing equals the Behaviour latency formula.
- Back-to-back: send 55, A3, 7E, 00, FF, C3, 3C, 5A, 81, 1E with no idle gap, rx_ready=1 -> all 10 words delivered in order, no overrun.
- Noise: 1-clock low glitch in idle -> no output, busy returns 0 within MID+2 clks. 1-clock inverted glitch at MID of bit 3 of 8'h00 -> received 8'h00 (majority vote).
- Framing: 8'hA5 with stop held low, then line low for 30 clks, then 8'h3C -> frame_err single pulse, no rx_valid for A5, 8'h3C received correctly.
- Backpressure: rx_ready=0; send 8'h11 then 8'h22 -> data_bits_rx=8'h11 held, one overrun pulse at the end of 8'h22. Raise rx_ready -> rx_valid drops the next cycle.
- Reset mid-frame: assert rst during DATA bit 4 for 1 clk -> all outputs 0 next edge. The following frame 8'hC3 is received correctly.
